// File: rtl/base_deserializer.sv
// Serial-to-parallel receiver for the base_serializer link, sampling ser_clock/ser_data in the
// system clock domain and handing each MSB-first word to a valid/ack holding register.
module base_deserializer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ser_clock,
  input  logic             ser_data,
  input  logic             ack,
  output logic [WIDTH-1:0] par_data,
  output logic             valid,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
  logic                   sclk_d_q, sclk_d_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [WIDTH-1:0]       par_data_q, par_data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic             sclk_s, sdat_s, rise, busy_w, complete, timeout;
  logic [WIDTH-1:0] word;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign sdat_s   = sdat_sync_q[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_d_q;
  assign busy_w   = (bit_cnt_q != '0);
  assign complete = rise && (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign word     = {shreg_q[WIDTH-2:0], sdat_s};
  // A rise in the timeout cycle keeps the bit, so timeout requires no rise.
  assign timeout  = busy_w && !rise && (idle_q == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], ser_clock};
    sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], ser_data};
    sclk_d_d    = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = idle_q;
    shreg_d     = shreg_q;
    par_data_d  = par_data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;

    if (rise) begin
      shreg_d = word;
      idle_d  = '0;
      if (complete) bit_cnt_d = '0;
      else          bit_cnt_d = bit_cnt_q + 1'b1;
    end else if (!busy_w) begin
      idle_d = '0;
    end else if (timeout) begin
      bit_cnt_d   = '0;
      idle_d      = '0;
      frame_err_d = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    if (valid_q && ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // Overrun set takes priority over the ack clear above.
    if (complete) begin
      if (!valid_q || ack) begin
        par_data_d = word;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q <= '0;
      sdat_sync_q <= '0;
      sclk_d_q    <= 1'b0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      shreg_q     <= '0;
      par_data_q  <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sdat_sync_q <= sdat_sync_d;
      sclk_d_q    <= sclk_d_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_q      <= idle_d;
      shreg_q     <= shreg_d;
      par_data_q  <= par_data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign par_data  = par_data_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_w;

endmodule

// File: doc/base_deserializer.md
Name: base_deserializer

Overview:
Downstream partner of base_serializer. It receives the ser_clock/ser_data pair, reassembles WIDTH-bit words MSB first and presents each word on a valid/ack holding register. It runs entirely in the system clock domain, synchronizing and edge-detecting ser_clock rather than clocking on it. Idle-gap detection re-aligns word boundaries, and overrun is flagged when the consumer is too slow.

Parameters:
WIDTH, 8, bits per word; must match the serializer word width.
SYNC_STAGES, 2, synchronizer flops on ser_clock and ser_data; minimum 2.
TIMEOUT, 64, clock cycles without a ser_clock rising edge mid-word before the partial word is discarded.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
ser_clock  input  1  serial bit clock from the serializer; data valid at its rising edge.
ser_data  input  1  serial data, MSB first.
ack  input  1  consumer accepts par_data; meaningful only while valid=1.
par_data  output  WIDTH  last completed word.
valid  output  1  par_data holds an unconsumed word.
overrun  output  1  sticky: a completed word was dropped because valid was still set.
frame_err  output  1  one-cycle pulse when a partial word is discarded by timeout.
busy  output  1  a word is partially received (bit_cnt != 0).

Behaviour:
- Reset (reset=1 at a clock edge) wins over everything. Afterwards: par_data=0, valid=0, overrun=0, frame_err=0, busy=0, bit_cnt=0, shift register=0, idle counter=0, and synchronizer flops=0. Reset mid-word discards the partial word with no frame_err.
- Synchronizers: ser_clock and ser_data each pass through SYNC_STAGES flops, giving sclk_s and sdat_s. Edge register sclk_d <= sclk_s.
- Rising-edge detect: rise = sclk_s & ~sclk_d. Only rising edges sample data; falling edges are ignored.
- On rise: shreg <= {shreg[WIDTH-2:0], sdat_s}, and the idle counter clears.
  - If bit_cnt < WIDTH-1, then bit_cnt increments.
  - If bit_cnt = WIDTH-1, the word is complete: bit_cnt returns to 0 and the word {shreg[WIDTH-2:0], sdat_s} is delivered in the same edge.
- Delivery:
  - If valid=0, or valid=1 with ack=1 in the same cycle: par_data loads the word and valid is 1 in the next cycle.
  - If valid=1 and ack=0: the word is dropped, par_data is unchanged and overrun is set to 1.
- ack handling:
  - ack=1 while valid=1 with no concurrent delivery: valid clears next cycle.
  - ack=1 also clears overrun, unless a new overrun is set in the same cycle; set wins.
  - ack while valid=0 is ignored.
- Latency: a pin rising edge is detected SYNC_STAGES+1 clock edges later. valid rises one clock after the detection cycle of the WIDTH-th edge.
- Timeout: the idle counter increments each cycle while busy=1 and no rise occurs.
  - When it reaches TIMEOUT-1 with no rise: bit_cnt <= 0, the idle counter clears, and frame_err pulses high for exactly 1 cycle. valid, par_data and overrun are unaffected.
  - A rise in the same cycle as the timeout wins: the bit is accepted and there is no frame_err.
  - The idle counter is held at 0 while busy=0.
- Input constraints (not checked): ser_clock high and low phases each ≥ SYNC_STAGES+1 clock periods, i.e. serializer divider ≥ 3 at default. ser_data stable from its change through the sampling of the following ser_clock rising edge.
- Widths: bit_cnt is clog2(WIDTH) bits; the idle counter is clog2(TIMEOUT) bits with saturation not required, because it clears at TIMEOUT-1.

Test Plan:
- Reset check: assert reset for 2 cycles with ser_clock toggling → par_data=0, valid=0, overrun=0, frame_err=0 and busy=0 throughout reset and on the first cycle after.
- Single word: drive 8'b10101010 MSB first at divider 3 (ser_clock period 6 clocks), ack held 0 → busy goes high after the first detected edge. valid=1 with par_data=8'hAA exactly one cycle after the 8th edge is detected. No frame_err.
- Back-to-back: send 8'h3C then 8'hC3 continuously, pulsing ack for 1 cycle when each valid appears → two deliveries, 3C then C3, and overrun stays 0. Also cover ack coincident with the 2nd delivery: valid stays 1 and par_data=C3.
- Overrun: send 8'h11 then 8'h22 with ack=0 → par_data stays 11, overrun=1 after the 2nd word. Then ack for 1 cycle → valid=0 and overrun=0 next cycle.
- Timeout re-sync: send 3 bits, then idle ser_clock for 70 cycles → frame_err single pulse, busy=0, valid unchanged. Then send 8'h5C → par_data=5C.
- Reset mid-word: after 5 bits of 8'hFF, pulse reset → all outputs zero. A following 8'h81 is received as 8'h81 with no frame_err.
